// File: rtl/reg_xfer_ctrl.sv
// Purpose : register-transfer sequencer driving a 4x8 register file (LOAD/MOV/ADD/INC per start pulse).
// Latency : accept edge to DONE entry is 2 (LOAD), 3 (MOV, INC) or 4 (ADD) clock edges; done pulses 1 cycle.
// Backpr. : start is only sampled in IDLE; requests arriving while busy are dropped, never queued.
// Ports   : clk/rst_n; start, op, rd_sel, rs_sel, imm request; x_in read-back from the register file;
//           wr, rd, ra, data_out register-file controls; busy, done, carry status.
module reg_xfer_ctrl #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [AW-1:0] rd_sel,
    input  logic [AW-1:0] rs_sel,
    input  logic [DW-1:0] imm,
    input  logic [DW-1:0] x_in,
    output logic          wr,
    output logic          rd,
    output logic [AW-1:0] ra,
    output logic [DW-1:0] data_out,
    output logic          busy,
    output logic          done,
    output logic          carry
);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_MOV  = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_INC  = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RDS  = 3'd1,
        RDD  = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t        state;
    logic [1:0]    op_q;
    logic [AW-1:0] rd_q;
    logic [DW-1:0] opa;

    // The destination operand is consumed straight from x_in on the edge that
    // leaves RDD, so the sum is ready as data_out on entry to WR.
    logic [DW:0] sum;
    always_comb begin
        sum = '0;
        if (op_q == OP_ADD) begin
            sum = {1'b0, x_in} + {1'b0, opa};
        end else begin
            sum = {1'b0, x_in} + {{DW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            opa      <= '0;
            wr       <= 1'b1;
            rd       <= 1'b0;
            ra       <= '0;
            data_out <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            carry    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    wr   <= 1'b1;
                    rd   <= 1'b0;
                    if (start) begin
                        op_q <= op;
                        rd_q <= rd_sel;
                        busy <= 1'b1;
                        case (op)
                            OP_LOAD: begin
                                state    <= WR;
                                ra       <= rd_sel;
                                data_out <= imm;
                                wr       <= 1'b0;
                                rd       <= 1'b1;
                            end
                            OP_INC: begin
                                state <= RDD;
                                ra    <= rd_sel;
                            end
                            default: begin
                                state <= RDS;
                                ra    <= rs_sel;
                            end
                        endcase
                    end else begin
                        busy <= 1'b0;
                        ra   <= '0;
                    end
                end
                RDS: begin
                    opa <= x_in;
                    ra  <= rd_q;
                    if (op_q == OP_MOV) begin
                        state    <= WR;
                        data_out <= x_in;
                        wr       <= 1'b0;
                        rd       <= 1'b1;
                    end else begin
                        state <= RDD;
                    end
                end
                RDD: begin
                    state    <= WR;
                    ra       <= rd_q;
                    data_out <= sum[DW-1:0];
                    carry    <= sum[DW];
                    wr       <= 1'b0;
                    rd       <= 1'b1;
                end
                WR: begin
                    state <= DONE;
                    wr    <= 1'b1;
                    rd    <= 1'b0;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    ra    <= '0;
                end
                default: begin
                    state <= IDLE;
                    wr    <= 1'b1;
                    rd    <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    ra    <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/reg_xfer_ctrl.md
Name: reg_xfer_ctrl

Overview:
Register-transfer sequencer that sits directly upstream of the 4x8 CPU register file (reg_function). It drives that block's wr, rd, RA and DATA_INPUT and reads its X output back. It executes one four-operation micro-instruction per start pulse: LOAD, MOV, ADD and INC. The register file acts on negedge clk. This block acts on posedge clk, so every control output is stable half a cycle before the register file samples it.

Parameters:
DW, 8, data width; must match register-file width.
AW, 2, register address width (4 registers).

Ports:
clk  in  1  system clock; all state updates on posedge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  request; sampled only in IDLE.
op  in  2  00 LOAD, 01 MOV, 10 ADD, 11 INC.
rd_sel  in  AW  destination register.
rs_sel  in  AW  source register (MOV, ADD).
imm  in  DW  immediate (LOAD).
x_in  in  DW  register-file X (value of R[RA], updated each negedge).
wr  out  1  to register file; 0 together with rd=1 commands a write.
rd  out  1  to register file.
ra  out  AW  to register file RA.
data_out  out  DW  to register file DATA_INPUT.
busy  out  1  high whenever the FSM is not in IDLE.
done  out  1  one-cycle pulse on completion.
carry  out  1  carry-out of the last ADD/INC.

Behaviour:
- Reset (async, immediate): state=IDLE; wr=1, rd=0, ra=0, data_out=0, busy=0, done=0, carry=0; operand latches=0.
- All outputs are registered. busy is high in every state except IDLE. done is high only in DONE.
- Start acceptance:
  - In IDLE with start=1, latch op, rd_sel, rs_sel and imm at the posedge.
  - start is ignored when not in IDLE; there is no queueing.
- States: IDLE, RDS, RDD, WR, DONE.
- Paths (cycle count from the accept edge to the edge that enters DONE):
  - LOAD: IDLE -> WR -> DONE (2 cycles).
  - MOV: IDLE -> RDS -> WR -> DONE (3 cycles).
  - ADD: IDLE -> RDS -> RDD -> WR -> DONE (4 cycles).
  - INC: IDLE -> RDD -> WR -> DONE (3 cycles).
  - DONE -> IDLE unconditionally, after 1 cycle.
- Read states:
  - RDS: ra=rs_sel. RDD: ra=rd_sel. In both, wr=1 and rd=0 (no write).
  - The register file updates X at the intervening negedge. The block captures x_in at the posedge that leaves the state: RDS into opa, RDD into opb.
  - x_in is not sampled in any other state.
- WR state:
  - ra=rd_sel, wr=0, rd=1 for exactly one cycle. The register file writes at that cycle's negedge.
  - data_out: LOAD -> imm; MOV -> opa; ADD -> opb+opa mod 2^DW; INC -> opb+1 mod 2^DW.
- Outputs outside WR:
  - wr=1 and rd=0 in IDLE, RDS, RDD and DONE.
  - data_out holds its last value outside WR.
  - ra returns to 0 in IDLE.
- carry:
  - Set to bit DW of the (DW+1)-bit sum on entry to WR, for ADD and INC only.
  - LOAD and MOV leave carry unchanged.
- Aliasing:
  - ADD with rs_sel==rd_sel doubles the register (Rd+Rd).
  - MOV with rs_sel==rd_sel rewrites the same value; both are legal.
- Reset mid-operation: return to IDLE immediately. wr goes to 1 asynchronously, so no write occurs after reset assertion. A write already committed at an earlier negedge stands.
- start held high continuously: a new op is accepted on the first IDLE cycle after DONE.

Test Plan:
(The bench instantiates reg_function on the same clk. The register file has no reset, so each scenario first LOADs all four registers.)
1. LOAD R2<-0x5A: wr=0/rd=1/ra=2 for exactly one cycle; done pulses 2 cycles after accept; R2=0x5A; carry unchanged.
2. LOAD R0=0x11, MOV R3<-R0: R3=0x11 after done; R0 still 0x11; done 3 cycles after accept.
3. ADD: R1=0xF0, R2=0x20, ADD R1<-R1+R2 -> R1=0x10, carry=1. Then ADD with R1=0x01, R2=0x02 -> R1=0x03, carry=0.
4. INC R3 with R3=0xFF -> R3=0x00, carry=1. Then LOAD R0 -> carry stays 1.
5. Start pulsed while busy during an ADD -> ignored. Exactly one wr-low cycle occurs, busy runs 4 cycles, then done.
6. rst_n asserted in RDD of an ADD -> wr=1 immediately; busy=0; carry=0; destination register keeps its pre-op value. A following LOAD completes normally.
